if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch (IF) stage of the 5-stage pipelined MIPS core. Sits directly upstream of the IF/ID pipeline register.
- Owns the PC and next-PC selection: sequential, branch target or jump target.
- Drives a single-outstanding-request instruction-memory handshake, absorbs memory wait states and hazard stalls, and presents instruction, PCplus4 and IF_Flush to IF/ID.
- Outputs are combinational so IF/ID captures them at the same edge the PC advances. No extra latency stage.

Parameters:
- RESET_PC, default 32'h0000_0000: PC value loaded on reset. Bits [1:0] must be 0.
- NOP_INSTR, default 32'h0000_0000: bubble word presented when no valid instruction is available.

Ports:
- clk  in  1  Core clock, rising edge.
- reset  in  1  Synchronous, active-high reset.
- PCWrite  in  1  From the hazard unit. 1 = IF/ID loads this cycle; 0 = stall (hold PC, IF/ID holds).
- Branch_taken  in  1  ID-stage branch resolved taken.
- Branch_target  in  32  Branch destination.
- Jump  in  1  ID-stage j/jal.
- Jump_addr  in  32  Full jump destination, already formed by ID.
- imem_req  out  1  Fetch request valid.
- imem_addr  out  32  Fetch address, word aligned.
- imem_ready  in  1  Memory returns imem_rdata this cycle for the outstanding request.
- imem_rdata  in  32  Fetched word.
- instruction  out  32  Word for the IF/ID register.
- PCplus4  out  32  pc+4 of the presented instruction.
- if_valid  out  1  instruction is a real fetched word, not a bubble.
- IF_Flush  out  1  Squash IF/ID this edge (nop insertion).

Behaviour:
- Internal state
  - pc[31:0], hold_buf[31:0], state ∈ {FETCH, HOLD, DRAIN}.
  - Reset values: pc = RESET_PC, hold_buf = 0, state = FETCH.
- Outputs while reset = 1
  - imem_req = 0, instruction = NOP_INSTR, if_valid = 0, IF_Flush = 0, PCplus4 = RESET_PC+4.
  - The first request issues in the cycle after reset deasserts.
- Redirect
  - redirect = PCWrite & (Branch_taken | Jump).
  - If both Branch_taken and Jump are set, Branch_taken wins.
  - Target low 2 bits are forced to 00.
  - Branch_taken/Jump are ignored while PCWrite = 0.
- IF_Flush = redirect, combinational, same cycle. On a redirect, instruction = NOP_INSTR and if_valid = 0.
- FETCH state: imem_req = 1, imem_addr = pc.
  - ready & PCWrite & !redirect: instruction = imem_rdata, if_valid = 1; pc <= pc+4; stay in FETCH. This gives one instruction per cycle with a zero-wait memory.
  - ready & !PCWrite: hold_buf <= imem_rdata; go to HOLD; pc unchanged; instruction = NOP_INSTR, if_valid = 0 (IF/ID is not loading).
  - ready & redirect: discard the data; pc <= target; stay in FETCH.
  - !ready & !redirect: instruction = NOP_INSTR, if_valid = 0; pc unchanged. The bubble enters IF/ID when PCWrite = 1.
  - !ready & redirect: pc <= target; go to DRAIN.
- HOLD state: imem_req = 0.
  - PCWrite & !redirect: instruction = hold_buf, if_valid = 1; pc <= pc+4; go to FETCH.
  - redirect: drop hold_buf; pc <= target; go to FETCH.
  - !PCWrite: remain in HOLD; outputs NOP_INSTR / if_valid = 0.
- DRAIN state: imem_req = 1, imem_addr = the old address held in a register. pc already holds the new target.
  - On imem_ready: discard the data; go to FETCH.
  - instruction = NOP_INSTR, if_valid = 0.
  - A further redirect in DRAIN updates pc only.
- Memory rule: while imem_req = 1 and imem_ready = 0, imem_addr is stable. At most one request is outstanding.
- PCplus4 = pc+4 in every state.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Reset asserted mid-request (any state): state is forced to FETCH and pc to RESET_PC at that edge. Any later imem_ready for the abandoned request is ignored only if reset was still asserted in that cycle.

Decomposition:
- Package mips_pkg holds NOP_INSTR, RESET_PC, and the fetch_state_t enum {FETCH, HOLD, DRAIN}.
- One sub-module, if_pc_reg: the 32-bit PC register with synchronous reset, load enable and next-PC mux (pc+4 / Branch_target / Jump_addr, branch priority).
- The FSM, hold_buf and the drain address register live in the top module.

Test Plan:
- Reset release, imem_ready tied to 1:
  - First imem_addr = 0x0 the cycle after reset.
  - Consecutive cycles present addresses 0x0, 0x4, 0x8 with rdata passed through, if_valid = 1 and PCplus4 = 0x4, 0x8, 0xC.
- imem_ready low for 3 cycles at pc = 0x10:
  - imem_addr is stable at 0x10 and three NOP bubbles appear with if_valid = 0.
  - The instruction is presented on the 4th cycle; pc then becomes 0x14.
- Stall via hold buffer:
  - PCWrite = 0 in the cycle imem returns 0x8C410004 at pc = 0x20: state goes to HOLD and imem_req drops.
  - After 2 stall cycles, PCWrite = 1 presents 0x8C410004 with PCplus4 = 0x24.
- Branch with a ready fetch: Branch_taken = 1, Branch_target = 0x100 with a ready fetch at pc = 0x40 → IF_Flush = 1 and instruction = NOP_INSTR that cycle; the next imem_addr is 0x100.
- Jump with a request outstanding:
  - Jump = 1, Jump_addr = 0x200 while a fetch is waiting at 0x40 → state goes to DRAIN with imem_addr held at 0x40.
  - The returned word is discarded; the next request is 0x200.
  - Variant: Branch_taken and Jump both set → the branch target is used.
- Wrap-around and mid-request reset:
  - RESET_PC = 0xFFFFFFFC → the second fetch address is 0x00000000.
  - Asserting reset in DRAIN → the next request after release is at RESET_PC with if_valid = 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end: default reset/bubble words
// and the instruction-fetch FSM encoding.
package mips_pkg;
   localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;
endpackage

// File: rtl/if_pc_reg.sv
// Program counter with synchronous reset, load enable and next-PC select
// (sequential / branch / jump, branch wins when both redirect sources fire).
module if_pc_reg
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_ld_en,
   input  logic        i_redirect,
   input  logic        i_branch_taken,
   input  logic [31:0] i_branch_target,
   input  logic [31:0] i_jump_addr,
   output logic [31:0] o_pc,
   output logic [31:0] o_pc_plus4
);
   logic [31:0] r_pc;
   logic [31:0] w_raw_target;
   logic [31:0] w_target;
   logic [31:0] w_next;

   assign w_raw_target = i_branch_taken ? i_branch_target : i_jump_addr;
   // Targets are forced word aligned regardless of what ID hands us.
   assign w_target     = {w_raw_target[31:2], 2'b00};
   assign o_pc_plus4   = r_pc + 32'd4;
   assign w_next       = i_redirect ? w_target : o_pc_plus4;
   assign o_pc         = r_pc;

   always_ff @(posedge clk) begin
      if (reset)
         r_pc <= RESET_PC;
      else if (i_ld_en)
         r_pc <= w_next;
   end
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC ownership, single-outstanding imem handshake,
// stall hold buffer and redirect draining, with combinational outputs to IF/ID.
module if_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
   parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        PCWrite,
   input  logic        Branch_taken,
   input  logic [31:0] Branch_target,
   input  logic        Jump,
   input  logic [31:0] Jump_addr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instruction,
   output logic [31:0] PCplus4,
   output logic        if_valid,
   output logic        IF_Flush
);
   fetch_state_t r_state, w_next_state;
   logic [31:0]  r_hold_buf;
   logic [31:0]  r_drain_addr;
   logic [31:0]  w_pc;
   logic         w_redirect;
   logic         w_pc_ld;
   logic         w_hold_ld;
   logic         w_drain_ld;

   assign w_redirect = !reset && PCWrite && (Branch_taken || Jump);
   assign IF_Flush   = w_redirect;

   if_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
      .clk            (clk),
      .reset          (reset),
      .i_ld_en        (w_pc_ld),
      .i_redirect     (w_redirect),
      .i_branch_taken (Branch_taken),
      .i_branch_target(Branch_target),
      .i_jump_addr    (Jump_addr),
      .o_pc           (w_pc),
      .o_pc_plus4     (PCplus4)
   );

   always_comb begin
      w_next_state = r_state;
      w_pc_ld      = 1'b0;
      w_hold_ld    = 1'b0;
      w_drain_ld   = 1'b0;
      imem_req     = 1'b0;
      imem_addr    = w_pc;
      instruction  = NOP_INSTR;
      if_valid     = 1'b0;
      case (r_state)
         FETCH: begin
            imem_req = 1'b1;
            if (w_redirect) begin
               w_pc_ld    = 1'b1;
               // An unanswered request must be seen through at its old address.
               w_drain_ld = !imem_ready;
               if (!imem_ready) w_next_state = DRAIN;
            end else if (imem_ready) begin
               if (PCWrite) begin
                  instruction = imem_rdata;
                  if_valid    = 1'b1;
                  w_pc_ld     = 1'b1;
               end else begin
                  w_hold_ld    = 1'b1;
                  w_next_state = HOLD;
               end
            end
         end
         HOLD: begin
            if (w_redirect) begin
               w_pc_ld      = 1'b1;
               w_next_state = FETCH;
            end else if (PCWrite) begin
               instruction  = r_hold_buf;
               if_valid     = 1'b1;
               w_pc_ld      = 1'b1;
               w_next_state = FETCH;
            end
         end
         DRAIN: begin
            imem_req  = 1'b1;
            imem_addr = r_drain_addr;
            if (w_redirect) w_pc_ld = 1'b1;
            if (imem_ready) w_next_state = FETCH;
         end
         default: w_next_state = FETCH;
      endcase
      if (reset) begin
         imem_req    = 1'b0;
         instruction = NOP_INSTR;
         if_valid    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= FETCH;
         r_hold_buf   <= 32'd0;
         r_drain_addr <= 32'd0;
      end else begin
         r_state <= w_next_state;
         if (w_hold_ld)  r_hold_buf   <= imem_rdata;
         if (w_drain_ld) r_drain_addr <= w_pc;
      end
   end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: stimulus pushes expected IF/ID words into a
// scoreboard queue, a negedge monitor pops them whenever IF/ID would load.
module tb_if_fetch_unit;
   logic        clk = 1'b0;
   logic        reset, PCWrite, Branch_taken, Jump, imem_ready;
   logic [31:0] Branch_target, Jump_addr, imem_rdata;
   logic        imem_req, if_valid, IF_Flush;
   logic [31:0] imem_addr, instruction, PCplus4;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
   } exp_t;
   exp_t exp_q[$];

   int n_chk  = 0;
   int n_fail = 0;

   if_fetch_unit #(.RESET_PC(32'h0), .NOP_INSTR(32'h0)) dut (
      .clk(clk), .reset(reset), .PCWrite(PCWrite),
      .Branch_taken(Branch_taken), .Branch_target(Branch_target),
      .Jump(Jump), .Jump_addr(Jump_addr),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .instruction(instruction), .PCplus4(PCplus4),
      .if_valid(if_valid), .IF_Flush(IF_Flush)
   );

   always #5 clk = ~clk;

   // Memory image: one special word at 0x20, otherwise address ^ 0x12340000.
   always_comb imem_rdata = (imem_addr == 32'h20) ? 32'h8C41_0004 : (imem_addr ^ 32'h1234_0000);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] instr, input logic [31:0] pc4);
      exp_t e;
      e.instr = instr;
      e.pc4   = pc4;
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (!reset && PCWrite && if_valid) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_valid: got instr %h expected no valid", instruction);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_instr", instruction, e.instr);
            chk("sb_pcplus4", PCplus4, e.pc4);
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected completion");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1);
   end

   initial begin
      reset = 1'b1; PCWrite = 1'b1; Branch_taken = 1'b0; Jump = 1'b0;
      Branch_target = '0; Jump_addr = '0; imem_ready = 1'b1;
      @(negedge clk);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, if_valid}, 32'd0);
      chk("rst_flush", {31'd0, IF_Flush}, 32'd0);
      chk("rst_instr", instruction, 32'h0);
      chk("rst_pcplus4", PCplus4, 32'h4);
      cyc();
      reset = 1'b0;

      // Zero-wait streaming from 0x0
      push(32'h1234_0000, 32'h4);  push(32'h1234_0004, 32'h8);
      push(32'h1234_0008, 32'hC);  push(32'h1234_000C, 32'h10);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("seq_addr", imem_addr, 32'(i * 4));
         chk("seq_req", {31'd0, imem_req}, 32'd1);
         cyc();
      end

      // Three wait states at 0x10
      imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("wait_addr", imem_addr, 32'h10);
         chk("wait_valid", {31'd0, if_valid}, 32'd0);
         cyc();
      end
      imem_ready = 1'b1;
      push(32'h1234_0010, 32'h14);
      @(negedge clk);
      chk("wait_done_addr", imem_addr, 32'h10);
      cyc();
      push(32'h1234_0014, 32'h18); push(32'h1234_0018, 32'h1C); push(32'h1234_001C, 32'h20);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("seq2_addr", imem_addr, 32'h14 + 32'(i * 4));
         cyc();
      end

      // Stall captured into hold buffer at 0x20
      PCWrite = 1'b0;
      @(negedge clk);
      chk("stall_cap_addr", imem_addr, 32'h20);
      chk("stall_cap_valid", {31'd0, if_valid}, 32'd0);
      cyc();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("hold_req", {31'd0, imem_req}, 32'd0);
         chk("hold_valid", {31'd0, if_valid}, 32'd0);
         cyc();
      end
      PCWrite = 1'b1;
      push(32'h8C41_0004, 32'h24);
      @(negedge clk);
      chk("hold_release_valid", {31'd0, if_valid}, 32'd1);
      chk("hold_release_req", {31'd0, imem_req}, 32'd0);
      cyc();
      for (int i = 0; i < 7; i++) begin
         push(32'h1234_0024 + 32'(i * 4), 32'h28 + 32'(i * 4));
         @(negedge clk);
         chk("seq3_addr", imem_addr, 32'h24 + 32'(i * 4));
         cyc();
      end

      // Branch at 0x40 with a ready fetch
      Branch_taken = 1'b1; Branch_target = 32'h100;
      @(negedge clk);
      chk("br_addr", imem_addr, 32'h40);
      chk("br_flush", {31'd0, IF_Flush}, 32'd1);
      chk("br_instr", instruction, 32'h0);
      chk("br_valid", {31'd0, if_valid}, 32'd0);
      cyc();
      Branch_target = 32'h40;
      @(negedge clk);
      chk("br_target_addr", imem_addr, 32'h100);
      cyc();
      Branch_taken = 1'b0;

      // Jump while the fetch at 0x40 is still waiting
      imem_ready = 1'b0; Jump = 1'b1; Jump_addr = 32'h200;
      @(negedge clk);
      chk("jmp_flush", {31'd0, IF_Flush}, 32'd1);
      chk("jmp_addr_before", imem_addr, 32'h40);
      cyc();
      Jump = 1'b0;
      @(negedge clk);
      chk("drain_addr", imem_addr, 32'h40);
      chk("drain_req", {31'd0, imem_req}, 32'd1);
      chk("drain_valid", {31'd0, if_valid}, 32'd0);
      cyc();
      imem_ready = 1'b1;
      @(negedge clk);
      chk("drain_ret_addr", imem_addr, 32'h40);
      chk("drain_ret_valid", {31'd0, if_valid}, 32'd0);
      cyc();
      push(32'h1234_0200, 32'h204);
      @(negedge clk);
      chk("jmp_target_addr", imem_addr, 32'h200);
      cyc();

      // Branch and jump together: branch wins
      Branch_taken = 1'b1; Branch_target = 32'h300; Jump = 1'b1; Jump_addr = 32'h400;
      @(negedge clk);
      chk("both_flush", {31'd0, IF_Flush}, 32'd1);
      cyc();
      Branch_taken = 1'b0;
      Jump_addr = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("both_addr", imem_addr, 32'h300);
      cyc();
      Jump = 1'b0;

      // Unaligned jump target, then pc+4 wrap
      push(32'hEDCB_FFFC, 32'h0);
      @(negedge clk);
      chk("align_addr", imem_addr, 32'hFFFF_FFFC);
      chk("wrap_pcplus4", PCplus4, 32'h0);
      cyc();
      push(32'h1234_0000, 32'h4);
      @(negedge clk);
      chk("wrap_addr", imem_addr, 32'h0);
      cyc();

      // Reset asserted while draining
      imem_ready = 1'b0; Jump = 1'b1; Jump_addr = 32'h500;
      cyc();
      Jump = 1'b0;
      @(negedge clk);
      chk("pre_rst_drain_addr", imem_addr, 32'h4);
      cyc();
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
      cyc();
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_addr", imem_addr, 32'h0);
      chk("post_rst_req", {31'd0, imem_req}, 32'd1);
      chk("post_rst_valid", {31'd0, if_valid}, 32'd0);
      cyc();
      imem_ready = 1'b1;
      push(32'h1234_0000, 32'h4);
      @(negedge clk);
      cyc();
      PCWrite = 1'b0;
      @(negedge clk);
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
